// File: rtl/mod_canon.sv
// Final canonicalisation stage: folds a 25-bit partially reduced residue into [0, P)
// and buffers the results in a 2-entry FIFO. Define MOD_CANON_STATS_EN to add corr_cnt.
module mod_canon #(
  parameter int              W = 24,
  parameter logic [W-1:0]    P = 24'd16777153
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [24:0]       in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [W-1:0]      out_data,
  output logic              out_valid,
  input  logic              out_ready
`ifdef MOD_CANON_STATS_EN
  ,output logic [15:0]      corr_cnt
`endif
);

  typedef enum logic {IDLE, CORR} state_t;

  localparam logic signed [25:0] PX = 26'(P);

  state_t             state, state_next;
  logic signed [25:0] x, x_next;
  logic               push, pop;

  logic [W-1:0]       mem [2];
  logic               rd_ptr, wr_ptr;
  logic [1:0]         count;

  assign in_ready  = (state == IDLE) && (count < 2'd2);
  assign out_valid = (count != 2'd0);
  assign out_data  = mem[rd_ptr];
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      x     <= '0;
    end else begin
      state <= state_next;
      x     <= x_next;
    end
  end

  // A negative value needs P added, a value at or above P needs it subtracted;
  // once neither applies the residue is canonical and is handed to the FIFO.
  always_comb begin
    state_next = state;
    x_next     = x;
    push       = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          x_next     = {in_data[24], in_data};
          state_next = CORR;
        end
      end
      CORR: begin
        if (x[25]) begin
          x_next = x + PX;
        end else if (x >= PX) begin
          x_next = x - PX;
        end else begin
          push       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Admission only happens with a free slot, so a push never meets a full FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= x[W-1:0];
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

`ifdef MOD_CANON_STATS_EN
  logic corr_step;
  assign corr_step = (state == CORR) && (x[25] || (x >= PX));

  always_ff @(posedge clk) begin
    if (rst) begin
      corr_cnt <= 16'd0;
    end else if (corr_step && (corr_cnt != 16'hFFFF)) begin
      corr_cnt <= corr_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mod_canon.sv
// Bench for mod_canon: arithmetic reference model with per-cycle comparison,
// plus directed vectors with hand-computed residues and latencies.
module tb_mod_canon;

  localparam longint PM = 16777153;

  logic        clk = 1'b0;
  logic        rst;
  logic [24:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] out_data;
  logic        out_valid;
  logic        out_ready;
`ifdef MOD_CANON_STATS_EN
  logic [15:0] corr_cnt;
`endif

  int nVectors = 0;
  int nMiscompares = 0;

  mod_canon dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef MOD_CANON_STATS_EN
    ,.corr_cnt (corr_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nVectors++;
    if (actual !== expected) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: residue and correction count come from plain modular arithmetic.
  longint m_q[$];
  bit     m_busy;
  int     m_left;
  longint m_result;
  int     m_corr;
  bit     started = 1'b0;

  always @(posedge clk) begin
    longint v;
    bit acc, do_pop;
    if (rst) begin
      m_q.delete();
      m_busy  = 1'b0;
      m_left  = 0;
      m_corr  = 0;
      started = 1'b1;
    end else if (started) begin
      acc    = in_valid && !m_busy && (m_q.size() < 2);
      do_pop = out_ready && (m_q.size() > 0);
      if (do_pop) void'(m_q.pop_front());
      if (m_busy) begin
        if (m_left == 0) begin
          m_q.push_back(m_result);
          m_busy = 1'b0;
        end else begin
          m_left--;
          if (m_corr < 65535) m_corr++;
        end
      end
      if (acc) begin
        v = in_data[24] ? longint'(in_data) - 64'sd33554432 : longint'(in_data);
        if (v < 0) m_left = int'((-v + PM - 1) / PM);
        else       m_left = int'(v / PM);
        m_result = ((v % PM) + PM) % PM;
        m_busy   = 1'b1;
      end
    end
  end

  // Compare process: every falling edge after the first reset.
  always @(negedge clk) begin
    if (started) begin
      checkOutput("in_ready", 32'(in_ready), 32'(!m_busy && (m_q.size() < 2)));
      checkOutput("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
      if (m_q.size() != 0) checkOutput("out_data", 32'(out_data), 32'(m_q[0]));
`ifdef MOD_CANON_STATS_EN
      checkOutput("corr_cnt", 32'(corr_cnt), 32'(m_corr));
`endif
    end
  end

  logic [23:0] popLog[$];
  always @(posedge clk) begin
    if (!rst && out_valid && out_ready) popLog.push_back(out_data);
  end

  // Drives in_data until it is accepted; returns just after the accepting edge.
  task automatic applyStimulus(input logic [24:0] value);
    int waited = 0;
    in_data  = value;
    in_valid = 1'b1;
    while (!in_ready && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!in_ready) begin
      checkOutput("accept_timeout", 32'(in_ready), 32'd1);
    end else begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic sendAndMeasure(input string name, input logic [24:0] value,
                                input logic [23:0] expData, input int expLat);
    int lat = 0;
`ifdef MOD_CANON_STATS_EN
    logic [15:0] cnt0;
    cnt0 = corr_cnt;
`endif
    applyStimulus(value);
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput({name, "_lat"}, 32'(lat), 32'(expLat));
    checkOutput({name, "_data"}, 32'(out_data), 32'(expData));
`ifdef MOD_CANON_STATS_EN
    checkOutput({name, "_corr"}, 32'(corr_cnt - cnt0), 32'(expLat - 1));
`endif
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  typedef struct {
    logic [24:0] din;
    logic [23:0] dout;
    int          lat;
  } vec_t;

  vec_t vecs[9] = '{
    '{25'd5,          24'd5,        1},
    '{25'd16777153,   24'd0,        2},
    '{25'h1FFFFFF,    24'd16777152, 2},
    '{25'h1000000,    24'd16777090, 3},
    '{25'd0,          24'd0,        1},
    '{25'd16777152,   24'd16777152, 1},
    '{25'h0FFFFFF,    24'd62,       2},
    '{25'h100003F,    24'd0,        2},
    '{25'h100003E,    24'd16777152, 3}
  };

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    tick(2);
    rst = 1'b0;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_data", 32'(out_data), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef MOD_CANON_STATS_EN
    checkOutput("rst_corr_cnt", 32'(corr_cnt), 32'd0);
`endif

    foreach (vecs[i]) begin
      sendAndMeasure($sformatf("vec%0d", i), vecs[i].din, vecs[i].dout, vecs[i].lat);
    end
    tick(3);

    // Backpressure: two results fill the FIFO, the third input must wait.
    out_ready = 1'b0;
    popLog.delete();
    applyStimulus(25'd1);
    applyStimulus(25'd2);
    in_data  = 25'd3;
    in_valid = 1'b1;
    tick(1);
    for (int k = 0; k < 4; k++) begin
      checkOutput("full_in_ready", 32'(in_ready), 32'd0);
      checkOutput("full_head", 32'(out_data), 32'd1);
      tick(1);
    end
    out_ready = 1'b1;
    applyStimulus(25'd3);
    tick(4);
    checkOutput("order_count", 32'(popLog.size()), 32'd3);
    if (popLog.size() == 3) begin
      checkOutput("order_0", 32'(popLog[0]), 32'd1);
      checkOutput("order_1", 32'(popLog[1]), 32'd2);
      checkOutput("order_2", 32'(popLog[2]), 32'd3);
    end

    // Reset mid-correction drops the in-flight value.
    tick(2);
    applyStimulus(25'h1FFFFFF);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    checkOutput("mid_rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("mid_rst_out_valid", 32'(out_valid), 32'd0);
`ifdef MOD_CANON_STATS_EN
    checkOutput("mid_rst_corr_cnt", 32'(corr_cnt), 32'd0);
`endif
    for (int k = 0; k < 3; k++) begin
      tick(1);
      checkOutput("mid_rst_no_output", 32'(out_valid), 32'd0);
    end

    sendAndMeasure("post_rst", 25'd7, 24'd7, 1);
    tick(3);

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
